ac_sequencer: RTL and testbench
===============================

# ac_sequencer

Execute-phase controller for the accumulator datapath of the basic computer. Accepts one decoded accumulator-class operation at a time over a valid/ready handshake and holds the architectural AC, E and DR registers. It drives the combinational ALU (operands, 4-bit function code, E input) through a fixed load/execute/respond sequence. It reports skip decisions and memory write-back data to the main control unit.

## Interface
- `WIDTH`, 16, datapath width of AC, DR and operand/result buses.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: operation request present.
- `req_ready` out 1: sequencer idle and able to accept.
- `req_op` in 4: operation select (encoding below).
- `req_operand` in WIDTH: memory word for memory-reference ops; ignored otherwise but still captured.
- `rsp_valid` out 1: one-cycle completion pulse; no backpressure.
- `rsp_skip` out 1: next instruction is to be skipped (valid with `rsp_valid`).
- `rsp_wen` out 1: memory write-back required (valid with `rsp_valid`).
- `rsp_wdata` out WIDTH: write-back word (valid with `rsp_valid`).
- `alu_ac` out WIDTH: ALU AC operand, the AC register.
- `alu_dr` out WIDTH: ALU DR operand, the DR register.
- `alu_code` out 4: ALU function code.
- `alu_ei` out 1: ALU E input, the E register.
- `alu_eo` in 1: ALU E output.
- `alu_dataout` in WIDTH: ALU result.
- `ac_q` out WIDTH, `e_q` out 1: architectural AC/E for observation.

## Operation
- `req_op` encoding, with `alu_code` in EXEC:
  - 0 AND 0000
  - 1 ADD 0001
  - 2 LDA 0010
  - 3 ISZ 1100 (DR+1)
  - 4 CLA 0111
  - 5 CLE 1000
  - 6 CMA 0011
  - 7 CME 1001
  - 8 CIR 0100
  - 9 CIL 0101
  - A INC 0110
  - B SPA, C SNA, D SZA, E SZE, F STA: 1101 (pass AC)
- `alu_code` = 1101 in every state other than EXEC.
- FSM: IDLE -> LOAD -> EXEC -> RESP -> IDLE. No other transitions except reset.
  - IDLE: `req_ready`=1. On `req_valid`, latch `req_op` and go to LOAD.
  - LOAD: DR <= `req_operand` (latched at accept).
  - EXEC: drive `alu_code`. At the closing edge:
    - AC <= `alu_dataout` for AND, ADD, LDA, CMA, CIR, CIL, INC, CLA.
    - E <= `alu_eo` for ADD, CIR, CIL, CLE, CME.
    - Register the response fields.
  - RESP: `rsp_valid`=1 for exactly one cycle.
- Response fields:
  - Skip ops, evaluated on AC/E as held during EXEC: SPA skip = AC[15]==0; SNA skip = AC[15]==1; SZA skip = AC==0; SZE skip = E==0.
  - ISZ: `rsp_wdata` = `alu_dataout`, `rsp_wen`=1, `rsp_skip` = (`alu_dataout`==0). AC and E are unchanged.
  - STA: `rsp_wdata` = AC, `rsp_wen`=1, `rsp_skip`=0.
  - All other ops: `rsp_wen`=0, `rsp_skip`=0, `rsp_wdata`=0.
- Arithmetic is modulo 2^WIDTH. Carry and rotate behaviour is owned by the ALU. The sequencer only routes `alu_eo` into E.

## Timing
- Reset values:
  - AC=0, E=0, DR=0, state=IDLE.
  - `req_ready`=1, `rsp_valid`=0, `rsp_skip`=0, `rsp_wen`=0, `rsp_wdata`=0.
  - `alu_code`=1101.
- Request accepted at edge N (`req_valid`&`req_ready`):
  - DR updated at edge N+1.
  - AC/E updated at edge N+2.
  - `rsp_valid` high between edges N+2 and N+3.
  - `req_ready` high again from edge N+3.
- Throughput: one op per 4 cycles. A held `req_valid` is re-accepted at N+4 and treats the held values as a new op.
- `req_ready` is low in LOAD, EXEC and RESP. `req_valid` in those states is ignored and no input is sampled.
- `req_operand`/`req_op` are sampled only at the accept edge. Later changes have no effect.
- `rst_n` low mid-operation: immediate return to reset values, no `rsp_valid`, partially executed op discarded (AC/E cleared).
- Outputs change only on the clock or on reset. No combinational path from request inputs to any output.

## Test plan
- Reset then LDA 0xFFFF, ADD 0x0001 -> AC=0x0000, E=1. A following SZA gives `rsp_skip`=1 and SZE gives `rsp_skip`=0.
- CLA, CLE, INC, CIR -> after CIR AC=0x0000, E=1. Then CIL -> AC=0x0001, E=0.
- ISZ operand 0xFFFF -> `rsp_wen`=1, `rsp_wdata`=0x0000, `rsp_skip`=1, AC unchanged. ISZ 0x0005 -> `rsp_wdata`=0x0006, `rsp_skip`=0.
- LDA 0x8001, then SNA -> skip=1, SPA -> skip=0, CMA -> AC=0x7FFE, STA -> `rsp_wen`=1, `rsp_wdata`=0x7FFE.
- `req_valid` held high with AND 0x0F0F after LDA 0x00FF -> accepts spaced exactly 4 cycles, `rsp_valid` one-cycle pulses, AC=0x000F.
- `rst_n` pulsed low during EXEC of ADD -> no `rsp_valid`, AC=0, E=0, `req_ready`=1 immediately after release.

Source files
------------

// File: rtl/ac_sequencer_if.sv
// ac_sequencer_if: request/response handshake between main control and the accumulator sequencer.
interface ac_sequencer_if #(parameter int WIDTH = 16);
  logic             req_valid;
  logic             req_ready;
  logic [3:0]       req_op;
  logic [WIDTH-1:0] req_operand;
  logic             rsp_valid;
  logic             rsp_skip;
  logic             rsp_wen;
  logic [WIDTH-1:0] rsp_wdata;
  modport master (output req_valid, req_op, req_operand,
                  input  req_ready, rsp_valid, rsp_skip, rsp_wen, rsp_wdata);
  modport slave  (input  req_valid, req_op, req_operand,
                  output req_ready, rsp_valid, rsp_skip, rsp_wen, rsp_wdata);
endinterface

// File: rtl/ac_sequencer.sv
// ac_sequencer: load/execute/respond controller owning AC, E and DR around an external combinational ALU.
module ac_sequencer #(parameter int WIDTH = 16) (
  input  logic             clk,
  input  logic             rst_n,
  ac_sequencer_if.slave    bus,
  output logic [WIDTH-1:0] alu_ac,
  output logic [WIDTH-1:0] alu_dr,
  output logic [3:0]       alu_code,
  output logic             alu_ei,
  input  logic             alu_eo,
  input  logic [WIDTH-1:0] alu_dataout,
  output logic [WIDTH-1:0] ac_q,
  output logic             e_q
);
  localparam logic [3:0] OP_AND = 4'h0, OP_ADD = 4'h1, OP_LDA = 4'h2, OP_ISZ = 4'h3,
                         OP_CLA = 4'h4, OP_CLE = 4'h5, OP_CMA = 4'h6, OP_CME = 4'h7,
                         OP_CIR = 4'h8, OP_CIL = 4'h9, OP_INC = 4'hA, OP_SPA = 4'hB,
                         OP_SNA = 4'hC, OP_SZA = 4'hD, OP_SZE = 4'hE, OP_STA = 4'hF;
  localparam logic [3:0] CODE_PASS = 4'b1101;
  typedef enum logic [1:0] {IDLE, LOAD, EXEC, RESP} state_e;
  state_e           state_q, state_d;
  logic [3:0]       op_q, op_d, exec_code;
  logic [WIDTH-1:0] opnd_q, opnd_d, dr_q, dr_d, ac_d, wdata_q, wdata_d;
  logic             e_d, skip_q, skip_d, wen_q, wen_d;
  always_comb begin
    case (op_q)
      OP_AND:  exec_code = 4'b0000;
      OP_ADD:  exec_code = 4'b0001;
      OP_LDA:  exec_code = 4'b0010;
      OP_ISZ:  exec_code = 4'b1100;
      OP_CLA:  exec_code = 4'b0111;
      OP_CLE:  exec_code = 4'b1000;
      OP_CMA:  exec_code = 4'b0011;
      OP_CME:  exec_code = 4'b1001;
      OP_CIR:  exec_code = 4'b0100;
      OP_CIL:  exec_code = 4'b0101;
      OP_INC:  exec_code = 4'b0110;
      default: exec_code = CODE_PASS;
    endcase
  end
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    opnd_d  = opnd_q;
    dr_d    = dr_q;
    ac_d    = ac_q;
    e_d     = e_q;
    skip_d  = 1'b0;
    wen_d   = 1'b0;
    wdata_d = '0;
    case (state_q)
      IDLE: if (bus.req_valid) begin
        state_d = LOAD;
        op_d    = bus.req_op;
        opnd_d  = bus.req_operand;
      end
      LOAD: begin
        state_d = EXEC;
        dr_d    = opnd_q;
      end
      EXEC: begin
        state_d = RESP;
        ac_d    = (op_q inside {OP_AND, OP_ADD, OP_LDA, OP_CMA, OP_CIR, OP_CIL, OP_INC, OP_CLA}) ? alu_dataout : ac_q;
        e_d     = (op_q inside {OP_ADD, OP_CIR, OP_CIL, OP_CLE, OP_CME}) ? alu_eo : e_q;
        // skip tests see AC/E as they stood before this op's write-back
        skip_d  = (op_q == OP_SPA) ? ~ac_q[WIDTH-1] :
                  (op_q == OP_SNA) ?  ac_q[WIDTH-1] :
                  (op_q == OP_SZA) ? (ac_q == '0) :
                  (op_q == OP_SZE) ? ~e_q :
                  (op_q == OP_ISZ) ? (alu_dataout == '0) : 1'b0;
        wen_d   = op_q inside {OP_ISZ, OP_STA};
        wdata_d = (op_q == OP_ISZ) ? alu_dataout : (op_q == OP_STA) ? ac_q : '0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      opnd_q  <= '0;
      dr_q    <= '0;
      ac_q    <= '0;
      e_q     <= 1'b0;
      skip_q  <= 1'b0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      opnd_q  <= opnd_d;
      dr_q    <= dr_d;
      ac_q    <= ac_d;
      e_q     <= e_d;
      skip_q  <= skip_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
    end
  end
  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_skip  = skip_q;
  assign bus.rsp_wen   = wen_q;
  assign bus.rsp_wdata = wdata_q;
  assign alu_ac        = ac_q;
  assign alu_dr        = dr_q;
  assign alu_ei        = e_q;
  assign alu_code      = (state_q == EXEC) ? exec_code : CODE_PASS;
endmodule

// File: tb/tb_ac_sequencer.sv
// tb_ac_sequencer: directed ops with a queue of hand-computed responses checked by an independent monitor.
module tb_ac_sequencer;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [15:0] alu_ac, alu_dr, alu_dataout, ac_q;
  logic [3:0]  alu_code;
  logic        alu_ei, alu_eo, e_q;
  int tests = 0, fails = 0, cyc = 0;
  typedef struct {logic skip; logic wen; logic [15:0] wdata; logic [15:0] ac; logic e; logic [3:0] code; int acc;} exp_t;
  exp_t sb[$];
  ac_sequencer_if #(16) bus();
  ac_sequencer #(.WIDTH(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus), .alu_ac(alu_ac), .alu_dr(alu_dr),
    .alu_code(alu_code), .alu_ei(alu_ei), .alu_eo(alu_eo), .alu_dataout(alu_dataout), .ac_q(ac_q), .e_q(e_q));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // reference ALU of the basic computer
  always_comb begin
    alu_eo = alu_ei;
    alu_dataout = alu_ac;
    case (alu_code)
      4'b0000: alu_dataout = alu_ac & alu_dr;
      4'b0001: {alu_eo, alu_dataout} = {1'b0, alu_ac} + {1'b0, alu_dr};
      4'b0010: alu_dataout = alu_dr;
      4'b0011: alu_dataout = ~alu_ac;
      4'b0100: {alu_dataout, alu_eo} = {alu_ei, alu_ac};
      4'b0101: {alu_eo, alu_dataout} = {alu_ac, alu_ei};
      4'b0110: alu_dataout = alu_ac + 16'd1;
      4'b0111: alu_dataout = '0;
      4'b1000: alu_eo = 1'b0;
      4'b1001: alu_eo = ~alu_ei;
      4'b1100: alu_dataout = alu_dr + 16'd1;
      default: ;
    endcase
  end
  function automatic logic [3:0] code_of(input logic [3:0] op);
    logic [3:0] t [0:10] = '{4'b0000, 4'b0001, 4'b0010, 4'b1100, 4'b0111, 4'b1000, 4'b0011, 4'b1001, 4'b0100, 4'b0101, 4'b0110};
    return (op <= 4'hA) ? t[op] : 4'b1101;
  endfunction
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask
  initial begin : monitor
    logic prev_valid = 1'b0;
    logic [3:0] prev_code = 4'b1101;
    exp_t x;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_valid = 1'b0;
        continue;
      end
      if (bus.rsp_valid) begin
        check("rsp_pulse_width", {31'd0, prev_valid}, 32'd0);
        if (sb.size() == 0) check("spurious_rsp", 32'd1, 32'd0);
        else begin
          x = sb.pop_front();
          check("rsp_skip", {31'd0, bus.rsp_skip}, {31'd0, x.skip});
          check("rsp_wen", {31'd0, bus.rsp_wen}, {31'd0, x.wen});
          check("rsp_wdata", {16'd0, bus.rsp_wdata}, {16'd0, x.wdata});
          check("ac", {16'd0, ac_q}, {16'd0, x.ac});
          check("e", {31'd0, e_q}, {31'd0, x.e});
          check("exec_code", {28'd0, prev_code}, {28'd0, x.code});
          check("resp_code", {28'd0, alu_code}, 32'hD);
          check("latency", cyc - x.acc, 32'd2);
        end
      end
      prev_valid = bus.rsp_valid;
      prev_code = alu_code;
    end
  end
  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) check("ready_timeout", 32'd0, 32'd1);
  endtask
  task automatic push(input logic [3:0] op, input logic sk, input logic wn, input logic [15:0] wd,
                      input logic [15:0] ac, input logic e);
    exp_t x;
    x.skip = sk; x.wen = wn; x.wdata = wd; x.ac = ac; x.e = e; x.code = code_of(op); x.acc = cyc;
    sb.push_back(x);
  endtask
  task automatic issue(input logic [3:0] op, input logic [15:0] opnd, input logic sk, input logic wn,
                       input logic [15:0] wd, input logic [15:0] ac, input logic e);
    wait_ready();
    bus.req_valid = 1'b1;
    bus.req_op = op;
    bus.req_operand = opnd;
    @(posedge clk);
    #1;
    push(op, sk, wn, wd, ac, e);
    bus.req_valid = 1'b0;
    bus.req_op = ~op;
    bus.req_operand = ~opnd;
  endtask
  initial begin
    int last;
    bus.req_valid = 1'b0;
    bus.req_op = 4'h0;
    bus.req_operand = 16'h0;
    repeat (2) @(negedge clk);
    check("rst_ready", {31'd0, bus.req_ready}, 32'd1);
    check("rst_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("rst_skip_wen", {30'd0, bus.rsp_skip, bus.rsp_wen}, 32'd0);
    check("rst_wdata", {16'd0, bus.rsp_wdata}, 32'd0);
    check("rst_code", {28'd0, alu_code}, 32'hD);
    check("rst_ac_e_dr", {15'd0, e_q, ac_q | alu_dr}, 32'd0);
    rst_n = 1'b1;
    issue(4'h2, 16'hFFFF, 0, 0, 16'h0000, 16'hFFFF, 0);
    issue(4'h1, 16'h0001, 0, 0, 16'h0000, 16'h0000, 1);
    issue(4'hD, 16'h5A5A, 1, 0, 16'h0000, 16'h0000, 1);
    issue(4'hE, 16'h5A5A, 0, 0, 16'h0000, 16'h0000, 1);
    issue(4'h4, 16'h5A5A, 0, 0, 16'h0000, 16'h0000, 1);
    issue(4'h5, 16'h5A5A, 0, 0, 16'h0000, 16'h0000, 0);
    issue(4'hA, 16'h5A5A, 0, 0, 16'h0000, 16'h0001, 0);
    issue(4'h8, 16'h5A5A, 0, 0, 16'h0000, 16'h0000, 1);
    issue(4'h9, 16'h5A5A, 0, 0, 16'h0000, 16'h0001, 0);
    issue(4'h3, 16'hFFFF, 1, 1, 16'h0000, 16'h0001, 0);
    issue(4'h3, 16'h0005, 0, 1, 16'h0006, 16'h0001, 0);
    issue(4'h2, 16'h8001, 0, 0, 16'h0000, 16'h8001, 0);
    issue(4'hC, 16'h5A5A, 1, 0, 16'h0000, 16'h8001, 0);
    issue(4'hB, 16'h5A5A, 0, 0, 16'h0000, 16'h8001, 0);
    issue(4'h6, 16'h5A5A, 0, 0, 16'h0000, 16'h7FFE, 0);
    issue(4'hF, 16'h5A5A, 0, 1, 16'h7FFE, 16'h7FFE, 0);
    issue(4'h7, 16'h5A5A, 0, 0, 16'h0000, 16'h7FFE, 1);
    issue(4'hB, 16'h5A5A, 1, 0, 16'h0000, 16'h7FFE, 1);
    issue(4'hE, 16'h5A5A, 0, 0, 16'h0000, 16'h7FFE, 1);
    issue(4'h2, 16'h00FF, 0, 0, 16'h0000, 16'h00FF, 1);
    wait_ready();
    bus.req_valid = 1'b1;
    bus.req_op = 4'h0;
    bus.req_operand = 16'h0F0F;
    @(posedge clk);
    #1;
    push(4'h0, 0, 0, 16'h0000, 16'h000F, 1);
    last = cyc;
    for (int k = 0; k < 2; k++) begin
      wait_ready();
      @(posedge clk);
      #1;
      push(4'h0, 0, 0, 16'h0000, 16'h000F, 1);
      check("held_spacing", cyc - last, 32'd4);
      last = cyc;
    end
    bus.req_valid = 1'b0;
    wait_ready();
    bus.req_valid = 1'b1;
    bus.req_op = 4'h1;
    bus.req_operand = 16'h0001;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_ac", {16'd0, ac_q}, 32'd0);
    check("mid_rst_e", {31'd0, e_q}, 32'd0);
    check("mid_rst_dr", {16'd0, alu_dr}, 32'd0);
    check("mid_rst_ready", {31'd0, bus.req_ready}, 32'd1);
    check("mid_rst_valid", {31'd0, bus.rsp_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_ready", {31'd0, bus.req_ready}, 32'd1);
    repeat (5) @(negedge clk);
    issue(4'h2, 16'h1234, 0, 0, 16'h0000, 16'h1234, 0);
    repeat (6) @(negedge clk);
    check("sb_drained", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
